// File: rtl/sysid_check_ctrl_pkg.sv
// Shared types and constants for the sysid check controller.
package sysid_check_ctrl_pkg;

  // One-hot controller state encoding.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_RD_ID = 5'b00010,
    ST_RD_TS = 5'b00100,
    ST_CPU   = 5'b01000,
    ST_FIN   = 5'b10000
  } state_t;

  // Bit positions inside fail_code.
  localparam int FAIL_ID = 0;
  localparam int FAIL_TS = 1;

  // Word addresses on the sysid slave.
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: reads the sysid slave's ID and timestamp words, compares
// them with the build-time expected values and reports pass/fail. Between
// checks the slave port is lent to a CPU read path.
// Optional feature: define SYSID_PERIODIC_EN to re-run the check after
// RECHECK_CYCLES idle cycles.
//
// state  | meaning
// IDLE   | waiting for a check trigger or a CPU read
// RD_ID  | slave address 0, capture ID compare
// RD_TS  | slave address 1, capture timestamp compare
// FIN    | publish pass/fail_code, set done
// CPU    | slave address from CPU, capture read data
module sysid_check_ctrl
  import sysid_check_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1764772539,
  parameter int unsigned RECHECK_CYCLES = 1_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        cpu_req,
  input  logic        cpu_address,
  output logic [31:0] cpu_readdata,
  output logic        cpu_valid,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code
);

  // A zero interval would make the periodic compare value wrap.
  if (RECHECK_CYCLES == 0) begin : g_param_chk
    $error("RECHECK_CYCLES must be nonzero");
  end

  state_t      r_state;
  state_t      w_next;
  logic        r_boot;
  logic        r_start_pend;
  logic        r_id_bad;
  logic        r_ts_bad;
  logic        r_done;
  logic        r_pass;
  logic [1:0]  r_fail_code;
  logic [31:0] r_cpu_rdata;
  logic        r_cpu_valid;
  logic        w_periodic;
  logic        w_trigger;
  logic        w_chk_start;
  logic        w_cpu_start;
  logic        w_busy;
  logic        w_addr;

  // Any reason to run a check; only acted upon in IDLE.
  assign w_trigger   = start | r_start_pend | r_boot | w_periodic;
  assign w_chk_start = (r_state == ST_IDLE) & w_trigger;
  // r_cpu_valid blocks re-entry while the requester still holds cpu_req.
  assign w_cpu_start = (r_state == ST_IDLE) & ~w_trigger & cpu_req & ~r_cpu_valid;

`ifdef SYSID_PERIODIC_EN
  localparam logic [31:0] LP_RECHECK_LAST = 32'(RECHECK_CYCLES - 1);
  logic [31:0] r_period_cnt;

  assign w_periodic = (r_state == ST_IDLE) && (r_period_cnt == LP_RECHECK_LAST);

  // Idle-cycle counter: restarts with every check, holds outside IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_period_cnt <= '0;
    end else if (w_chk_start) begin
      r_period_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_period_cnt <= r_period_cnt + 32'd1;
    end
  end
`else
  assign w_periodic = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; a check trigger wins over a CPU request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger)        w_next = ST_RD_ID;
        else if (w_cpu_start) w_next = ST_CPU;
      end
      ST_RD_ID: w_next = ST_RD_TS;
      ST_RD_TS: w_next = ST_FIN;
      ST_FIN:   w_next = ST_IDLE;
      ST_CPU:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs: busy and the slave address.
  always_comb begin
    w_busy = 1'b0;
    w_addr = ADDR_ID;
    case (r_state)
      ST_RD_ID: begin w_busy = 1'b1; w_addr = ADDR_ID; end
      ST_RD_TS: begin w_busy = 1'b1; w_addr = ADDR_TS; end
      ST_CPU:   w_addr = cpu_address;
      default:  begin w_busy = 1'b0; w_addr = ADDR_ID; end
    endcase
  end

  // Compare capture, result publication, start latch and CPU read return.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_boot       <= 1'b1;
      r_start_pend <= 1'b0;
      r_id_bad     <= 1'b0;
      r_ts_bad     <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_code  <= 2'b00;
      r_cpu_rdata  <= '0;
      r_cpu_valid  <= 1'b0;
    end else begin
      if (w_chk_start) begin
        r_boot       <= 1'b0;
        r_start_pend <= 1'b0;
        r_done       <= 1'b0;
      end else if (start) begin
        r_start_pend <= 1'b1;
      end
      if (r_state == ST_RD_ID) r_id_bad <= (sysid_readdata != EXPECTED_ID);
      if (r_state == ST_RD_TS) r_ts_bad <= (sysid_readdata != EXPECTED_TS);
      if (r_state == ST_FIN) begin
        r_done               <= 1'b1;
        r_pass               <= ~(r_id_bad | r_ts_bad);
        r_fail_code[FAIL_ID] <= r_id_bad;
        r_fail_code[FAIL_TS] <= r_ts_bad;
      end
      if (r_state == ST_CPU) r_cpu_rdata <= sysid_readdata;
      r_cpu_valid <= (r_state == ST_CPU);
    end
  end

  assign busy          = w_busy;
  assign sysid_address = w_addr;
  assign done          = r_done;
  assign pass          = r_pass;
  assign fail_code     = r_fail_code;
  assign cpu_readdata  = r_cpu_rdata;
  assign cpu_valid     = r_cpu_valid;

endmodule
